// File: rtl/reorder_buffer_pkg.sv
// Shared types, sizes and packet helpers for the reorder buffer.
// The ROB depth and register-file sizes live here so every file sees one
// consistent set of widths. Packet helpers convert between the renamer-side
// packet formats (RruToRob1/RruToRob2/RobToRru) and the ROB's own entry type.
package reorder_buffer_pkg;

  localparam int NUM_ENTRIES = 32;   // power of 2, >= 4
  localparam int NUM_PHYREG  = 128;
  localparam int NUM_ARCHREG = 32;

  localparam int IDX_W  = $clog2(NUM_ENTRIES);
  localparam int PREG_W = $clog2(NUM_PHYREG);
  localparam int AREG_W = $clog2(NUM_ARCHREG);
  localparam int CNT_W  = IDX_W + 1;

  localparam logic [CNT_W-1:0] ROB_FULL = CNT_W'(NUM_ENTRIES);

  typedef logic [IDX_W-1:0]  RobIndex_T;
  typedef logic [PREG_W-1:0] PhyRegisterId_T;
  typedef logic [AREG_W-1:0] ArchRegisterId_T;

  typedef struct packed {
    logic            valid;
    logic            done;
    logic            exc;
    logic            dst_valid;
    ArchRegisterId_T areg;
    PhyRegisterId_T  dst_preg;
    PhyRegisterId_T  prev_preg;
  } RobEntry_T;

  localparam int ENTRY_W = $bits(RobEntry_T);

  typedef enum logic {
    ROB_RUN  = 1'b0,
    ROB_WALK = 1'b1
  } RobState_T;

  // Renamer -> ROB, destination descriptor.
  typedef struct packed {
    logic            dst_valid;
    ArchRegisterId_T areg;
  } RruToRob1_T;

  // Renamer -> ROB, physical mappings (new and displaced).
  typedef struct packed {
    PhyRegisterId_T dst_preg;
    PhyRegisterId_T prev_preg;
  } RruToRob2_T;

  // ROB -> renamer, retirement report.
  typedef struct packed {
    logic           valid;
    logic           free;
    PhyRegisterId_T preg;
  } RobToRru_T;

  function automatic RruToRob1_T encap_rru_to_rob1(input logic dst_valid,
                                                   input ArchRegisterId_T areg);
    RruToRob1_T p;
    p.dst_valid = dst_valid;
    p.areg      = areg;
    return p;
  endfunction

  function automatic RruToRob2_T encap_rru_to_rob2(input PhyRegisterId_T dst_preg,
                                                   input PhyRegisterId_T prev_preg);
    RruToRob2_T p;
    p.dst_preg  = dst_preg;
    p.prev_preg = prev_preg;
    return p;
  endfunction

  // A freshly allocated entry: valid, not yet completed, no exception.
  function automatic RobEntry_T decap_rru_to_rob(input RruToRob1_T p1,
                                                 input RruToRob2_T p2);
    RobEntry_T e;
    e.valid     = 1'b1;
    e.done      = 1'b0;
    e.exc       = 1'b0;
    e.dst_valid = p1.dst_valid;
    e.areg      = p1.areg;
    e.dst_preg  = p2.dst_preg;
    e.prev_preg = p2.prev_preg;
    return e;
  endfunction

  function automatic RobToRru_T encap_rob_to_rru(input logic valid,
                                                 input logic free,
                                                 input PhyRegisterId_T preg);
    RobToRru_T p;
    p.valid = valid;
    p.free  = free;
    p.preg  = preg;
    return p;
  endfunction

endpackage

// File: rtl/reorder_buffer_rob_entry_array.sv
// Entry storage for the reorder buffer.
// Ports:
//   i_clk, i_rst          clock, synchronous active-high reset
//   i_alloc_we/idx/entry  write a whole new entry at the tail
//   i_wb_we/idx/exc       mark a valid entry done, record its exception flag
//   i_clr_we/idx          retire or roll back an entry (drops valid/done/exc)
//   i_head_idx, o_head_*  async read of the fields retirement needs
//   i_walk_idx, o_walk_*  async read of the fields rollback needs
module rob_entry_array
  import reorder_buffer_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_alloc_we,
  input  logic [IDX_W-1:0]  i_alloc_idx,
  input  logic [ENTRY_W-1:0] i_alloc_entry,
  input  logic              i_wb_we,
  input  logic [IDX_W-1:0]  i_wb_idx,
  input  logic              i_wb_exc,
  input  logic              i_clr_we,
  input  logic [IDX_W-1:0]  i_clr_idx,
  input  logic [IDX_W-1:0]  i_head_idx,
  output logic              o_head_valid,
  output logic              o_head_done,
  output logic              o_head_exc,
  output logic              o_head_dst_valid,
  output logic [PREG_W-1:0] o_head_prev_preg,
  input  logic [IDX_W-1:0]  i_walk_idx,
  output logic              o_walk_dst_valid,
  output logic [AREG_W-1:0] o_walk_areg,
  output logic [PREG_W-1:0] o_walk_dst_preg,
  output logic [PREG_W-1:0] o_walk_prev_preg
);

  RobEntry_T r_mem [NUM_ENTRIES];
  RobEntry_T w_alloc_entry;

  assign w_alloc_entry = RobEntry_T'(i_alloc_entry);

  // NOTE: only the valid/done/exc control bits are reset; the payload is
  // always rewritten by an allocation before anything reads it, so it needs
  // no reset and can map onto plain storage.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        r_mem[i].valid <= 1'b0;
        r_mem[i].done  <= 1'b0;
        r_mem[i].exc   <= 1'b0;
      end
    end else begin
      // Completion for an entry that is not live is silently dropped.
      if (i_wb_we && r_mem[i_wb_idx].valid) begin
        r_mem[i_wb_idx].done <= 1'b1;
        r_mem[i_wb_idx].exc  <= i_wb_exc;
      end
      if (i_alloc_we) begin
        r_mem[i_alloc_idx] <= w_alloc_entry;
      end
      if (i_clr_we) begin
        r_mem[i_clr_idx].valid <= 1'b0;
        r_mem[i_clr_idx].done  <= 1'b0;
        r_mem[i_clr_idx].exc   <= 1'b0;
      end
    end
  end

  assign o_head_valid     = r_mem[i_head_idx].valid;
  assign o_head_done      = r_mem[i_head_idx].done;
  assign o_head_exc       = r_mem[i_head_idx].exc;
  assign o_head_dst_valid = r_mem[i_head_idx].dst_valid;
  assign o_head_prev_preg = r_mem[i_head_idx].prev_preg;

  assign o_walk_dst_valid = r_mem[i_walk_idx].dst_valid;
  assign o_walk_areg      = r_mem[i_walk_idx].areg;
  assign o_walk_dst_preg  = r_mem[i_walk_idx].dst_preg;
  assign o_walk_prev_preg = r_mem[i_walk_idx].prev_preg;

endmodule

// File: rtl/reorder_buffer.sv
// In-order retirement buffer behind register renaming.
// Allocates at the tail (alloc_idx is the index handed to the renamer),
// marks entries complete on writeback, retires one entry per cycle from the
// head and reports the displaced phys reg for freeing. An excepting head
// switches to WALK, which undoes mappings youngest-first and then flushes.
// Ports:
//   SIG_CLK, SIG_RST          clock, synchronous active-high reset
//   alloc_valid/ready/idx     allocation handshake, tail index (comb)
//   alloc_dst_*/prev_preg     renamed destination of the allocating instr
//   wb_valid/idx/exc          completion reports
//   commit_valid/free/preg    registered retirement pulse
//   rb_valid/areg/prev/free   registered rollback step
//   flush_valid/idx           registered pulse after the last rollback step
//   count                     registered occupancy
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              SIG_CLK,
  input  logic              SIG_RST,
  input  logic              alloc_valid,
  output logic              alloc_ready,
  output logic [IDX_W-1:0]  alloc_idx,
  input  logic              alloc_dst_valid,
  input  logic [AREG_W-1:0] alloc_dst_areg,
  input  logic [PREG_W-1:0] alloc_dst_preg,
  input  logic [PREG_W-1:0] alloc_prev_preg,
  input  logic              wb_valid,
  input  logic [IDX_W-1:0]  wb_idx,
  input  logic              wb_exc,
  output logic              commit_valid,
  output logic              commit_free,
  output logic [PREG_W-1:0] commit_preg,
  output logic              rb_valid,
  output logic [AREG_W-1:0] rb_areg,
  output logic [PREG_W-1:0] rb_prev_preg,
  output logic [PREG_W-1:0] rb_free_preg,
  output logic              flush_valid,
  output logic [IDX_W-1:0]  flush_idx,
  output logic [CNT_W-1:0]  count
);

  RobState_T  r_state, w_state_next;
  RobIndex_T  r_head, w_head_next;
  RobIndex_T  r_tail, w_tail_next;
  RobIndex_T  r_walk_ptr, w_walk_next;
  RobIndex_T  r_exc_idx, w_exc_idx_next;
  logic [CNT_W-1:0] r_count, w_count_next;

  RobToRru_T       r_commit, w_commit_next;
  logic            r_rb_valid, w_rb_valid;
  ArchRegisterId_T r_rb_areg, w_rb_areg;
  PhyRegisterId_T  r_rb_prev_preg, w_rb_prev_preg;
  PhyRegisterId_T  r_rb_free_preg, w_rb_free_preg;
  logic            r_flush_valid, w_flush_valid;
  RobIndex_T       r_flush_idx, w_flush_idx;

  logic            w_head_valid, w_head_done, w_head_exc, w_head_dst_valid;
  PhyRegisterId_T  w_head_prev_preg;
  logic            w_walk_dst_valid;
  ArchRegisterId_T w_walk_areg;
  PhyRegisterId_T  w_walk_dst_preg, w_walk_prev_preg;

  logic      w_run, w_alloc_fire, w_head_ready, w_commit_fire, w_exc_start;
  logic      w_walk_last;
  RobEntry_T w_alloc_entry;

  assign w_run         = (r_state == ROB_RUN);
  assign alloc_ready   = w_run && (r_count < ROB_FULL);
  assign alloc_idx     = r_tail;
  assign w_alloc_fire  = alloc_valid && alloc_ready;
  assign w_head_ready  = w_head_valid && w_head_done;
  assign w_commit_fire = w_run && w_head_ready && !w_head_exc;
  assign w_exc_start   = w_run && w_head_ready && w_head_exc;
  assign w_walk_last   = (r_walk_ptr == r_head);

  assign w_alloc_entry = decap_rru_to_rob(
      encap_rru_to_rob1(alloc_dst_valid, alloc_dst_areg),
      encap_rru_to_rob2(alloc_dst_preg, alloc_prev_preg));

  rob_entry_array u_entries (
    .i_clk            (SIG_CLK),
    .i_rst            (SIG_RST),
    .i_alloc_we       (w_alloc_fire),
    .i_alloc_idx      (r_tail),
    .i_alloc_entry    (w_alloc_entry),
    .i_wb_we          (w_run && wb_valid),
    .i_wb_idx         (wb_idx),
    .i_wb_exc         (wb_exc),
    .i_clr_we         (w_commit_fire || !w_run),
    .i_clr_idx        (w_run ? r_head : r_walk_ptr),
    .i_head_idx       (r_head),
    .o_head_valid     (w_head_valid),
    .o_head_done      (w_head_done),
    .o_head_exc       (w_head_exc),
    .o_head_dst_valid (w_head_dst_valid),
    .o_head_prev_preg (w_head_prev_preg),
    .i_walk_idx       (r_walk_ptr),
    .o_walk_dst_valid (w_walk_dst_valid),
    .o_walk_areg      (w_walk_areg),
    .o_walk_dst_preg  (w_walk_dst_preg),
    .o_walk_prev_preg (w_walk_prev_preg)
  );

  // NOTE: every signal gets its default before the case statement, so no
  // path through this block leaves a value unassigned and no latch appears.
  always_comb begin
    w_state_next   = r_state;
    w_head_next    = r_head;
    w_tail_next    = r_tail;
    w_walk_next    = r_walk_ptr;
    w_exc_idx_next = r_exc_idx;
    w_count_next   = r_count;
    w_commit_next  = '0;
    w_rb_valid     = 1'b0;
    w_rb_areg      = '0;
    w_rb_prev_preg = '0;
    w_rb_free_preg = '0;
    w_flush_valid  = 1'b0;
    w_flush_idx    = '0;
    case (r_state)
      ROB_RUN: begin
        if (w_alloc_fire) w_tail_next = r_tail + 1'b1;
        if (w_commit_fire) begin
          w_head_next   = r_head + 1'b1;
          w_commit_next = encap_rob_to_rru(1'b1, w_head_dst_valid, w_head_prev_preg);
        end
        w_count_next = r_count + CNT_W'(w_alloc_fire) - CNT_W'(w_commit_fire);
        if (w_exc_start) begin
          w_state_next   = ROB_WALK;
          // Start from the updated tail so an instr allocated in this very
          // cycle (its index already handed out) is also rolled back.
          w_walk_next    = w_tail_next - 1'b1;
          w_exc_idx_next = r_head;
        end
      end
      ROB_WALK: begin
        w_rb_valid     = w_walk_dst_valid;
        w_rb_areg      = w_walk_areg;
        w_rb_prev_preg = w_walk_prev_preg;
        w_rb_free_preg = w_walk_dst_preg;
        if (w_walk_last) begin
          w_tail_next   = r_head;
          w_count_next  = '0;
          w_state_next  = ROB_RUN;
          w_flush_valid = 1'b1;
          w_flush_idx   = r_exc_idx;
        end else begin
          w_walk_next = r_walk_ptr - 1'b1;
        end
      end
      default: w_state_next = ROB_RUN;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the values from before this edge, independent of statement order.
  always_ff @(posedge SIG_CLK) begin
    if (SIG_RST) begin
      r_state        <= ROB_RUN;
      r_head         <= '0;
      r_tail         <= '0;
      r_walk_ptr     <= '0;
      r_exc_idx      <= '0;
      r_count        <= '0;
      r_commit       <= '0;
      r_rb_valid     <= 1'b0;
      r_rb_areg      <= '0;
      r_rb_prev_preg <= '0;
      r_rb_free_preg <= '0;
      r_flush_valid  <= 1'b0;
      r_flush_idx    <= '0;
    end else begin
      r_state        <= w_state_next;
      r_head         <= w_head_next;
      r_tail         <= w_tail_next;
      r_walk_ptr     <= w_walk_next;
      r_exc_idx      <= w_exc_idx_next;
      r_count        <= w_count_next;
      r_commit       <= w_commit_next;
      r_rb_valid     <= w_rb_valid;
      r_rb_areg      <= w_rb_areg;
      r_rb_prev_preg <= w_rb_prev_preg;
      r_rb_free_preg <= w_rb_free_preg;
      r_flush_valid  <= w_flush_valid;
      r_flush_idx    <= w_flush_idx;
    end
  end

  assign commit_valid = r_commit.valid;
  assign commit_free  = r_commit.free;
  assign commit_preg  = r_commit.preg;
  assign rb_valid     = r_rb_valid;
  assign rb_areg      = r_rb_areg;
  assign rb_prev_preg = r_rb_prev_preg;
  assign rb_free_preg = r_rb_free_preg;
  assign flush_valid  = r_flush_valid;
  assign flush_idx    = r_flush_idx;
  assign count        = r_count;

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a per-cycle vector table for the
// basic retire paths, then hand-written sequences for full/wrap, exception
// walks and reset mid-walk. Commit and rollback pulses are compared against
// expectation queues filled when the stimulus is driven.
module tb_reorder_buffer;

  logic       SIG_CLK, SIG_RST;
  logic       alloc_valid, alloc_ready;
  logic [4:0] alloc_idx;
  logic       alloc_dst_valid;
  logic [4:0] alloc_dst_areg;
  logic [6:0] alloc_dst_preg, alloc_prev_preg;
  logic       wb_valid;
  logic [4:0] wb_idx;
  logic       wb_exc;
  logic       commit_valid, commit_free;
  logic [6:0] commit_preg;
  logic       rb_valid;
  logic [4:0] rb_areg;
  logic [6:0] rb_prev_preg, rb_free_preg;
  logic       flush_valid;
  logic [4:0] flush_idx;
  logic [5:0] count;

  reorder_buffer dut (
    .SIG_CLK(SIG_CLK), .SIG_RST(SIG_RST),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready), .alloc_idx(alloc_idx),
    .alloc_dst_valid(alloc_dst_valid), .alloc_dst_areg(alloc_dst_areg),
    .alloc_dst_preg(alloc_dst_preg), .alloc_prev_preg(alloc_prev_preg),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_exc(wb_exc),
    .commit_valid(commit_valid), .commit_free(commit_free), .commit_preg(commit_preg),
    .rb_valid(rb_valid), .rb_areg(rb_areg), .rb_prev_preg(rb_prev_preg),
    .rb_free_preg(rb_free_preg), .flush_valid(flush_valid), .flush_idx(flush_idx),
    .count(count)
  );

  initial begin
    SIG_CLK = 1'b0;
    forever #5 SIG_CLK = ~SIG_CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [6:0] preg; logic free; } cexp_t;
  typedef struct { logic [4:0] areg; logic [6:0] prev; logic [6:0] freep; } rexp_t;

  typedef struct {
    logic av; logic dv; logic [4:0] areg; logic [6:0] dp; logic [6:0] pp;
    logic wv; logic [4:0] wi; logic we;
    logic exp_ready; logic [4:0] exp_idx; logic [5:0] exp_cnt; logic exp_cv;
  } vec_t;

  cexp_t cq[$];
  rexp_t rbq[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  vec_t  vecs[22];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance one clock and compare any commit/rollback pulse with the queues.
  task automatic tick();
    cexp_t c;
    rexp_t r;
    @(posedge SIG_CLK);
    #1;
    if (commit_valid) begin
      if (cq.size() == 0) check("commit_unexpected", 1, 0);
      else begin
        c = cq.pop_front();
        check("commit_preg", commit_preg, c.preg);
        check("commit_free", commit_free, c.free);
      end
    end
    if (rb_valid) begin
      if (rbq.size() == 0) check("rb_unexpected", 1, 0);
      else begin
        r = rbq.pop_front();
        check("rb_areg", rb_areg, r.areg);
        check("rb_prev_preg", rb_prev_preg, r.prev);
        check("rb_free_preg", rb_free_preg, r.freep);
      end
    end
  endtask

  task automatic idle_inputs();
    alloc_valid = 0; alloc_dst_valid = 0; alloc_dst_areg = 0;
    alloc_dst_preg = 0; alloc_prev_preg = 0;
    wb_valid = 0; wb_idx = 0; wb_exc = 0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_count"}, count, 0);
    check({tag, "_alloc_idx"}, alloc_idx, 0);
    check({tag, "_alloc_ready"}, alloc_ready, 1);
    check({tag, "_commit"}, {commit_valid, commit_free, commit_preg}, 0);
    check({tag, "_rb"}, {rb_valid, rb_areg, rb_prev_preg, rb_free_preg}, 0);
    check({tag, "_flush"}, {flush_valid, flush_idx}, 0);
  endtask

  task automatic do_reset();
    SIG_RST = 1;
    tick();
    SIG_RST = 0;
    cq.delete();
    rbq.delete();
  endtask

  task automatic alloc(input logic dv, input int areg, input int dp, input int pp,
                       input logic expect_commit);
    alloc_valid = 1; alloc_dst_valid = dv; alloc_dst_areg = 5'(areg);
    alloc_dst_preg = 7'(dp); alloc_prev_preg = 7'(pp);
    if (expect_commit) cq.push_back('{preg: 7'(pp), free: dv});
    tick();
    alloc_valid = 0;
  endtask

  task automatic wb_drive(input int idx, input logic exc);
    wb_valid = 1; wb_idx = 5'(idx); wb_exc = exc;
    tick();
    wb_valid = 0; wb_exc = 0;
  endtask

  // Called right after the writeback that marks the head as excepting.
  task automatic run_walk(input int steps, input int fidx, input logic drive_wb);
    int  t;
    logic seen;
    t = 1;
    seen = 0;
    while (t <= 40 && !seen) begin
      if (drive_wb && t > 1) begin
        wb_valid = 1; wb_idx = 5'd2; wb_exc = 0;
      end
      tick();
      if (flush_valid) begin
        seen = 1;
        check("flush_cycle", t, steps + 1);
        check("flush_idx", flush_idx, fidx);
        check("flush_count", count, 0);
        check("flush_rb_left", rbq.size(), 0);
      end else begin
        check("walk_alloc_ready", alloc_ready, 0);
      end
      t++;
    end
    wb_valid = 0;
    if (!seen) check("flush_timeout", 0, 1);
  endtask

  initial begin
    // av dv areg dp pp | wv wi we | ready idx cnt cv
    vecs[0]  = '{1, 1, 1, 50, 40, 0, 0, 0, 1, 1, 1, 0};
    vecs[1]  = '{1, 1, 2, 51, 41, 0, 0, 0, 1, 2, 2, 0};
    vecs[2]  = '{1, 1, 3, 52, 42, 0, 0, 0, 1, 3, 3, 0};
    vecs[3]  = '{0, 0, 0, 0, 0,   1, 2, 0, 1, 3, 3, 0};
    vecs[4]  = '{0, 0, 0, 0, 0,   1, 1, 0, 1, 3, 3, 0};
    vecs[5]  = '{0, 0, 0, 0, 0,   1, 0, 0, 1, 3, 3, 0};
    vecs[6]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 2, 1};
    vecs[7]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 1, 1};
    vecs[8]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 0, 1};
    vecs[9]  = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 3, 0, 0};
    vecs[10] = '{1, 0, 7, 99, 9,  0, 0, 0, 1, 4, 1, 0};
    vecs[11] = '{0, 0, 0, 0, 0,   1, 3, 0, 1, 4, 1, 0};
    vecs[12] = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 4, 0, 1};
    vecs[13] = '{1, 1, 5, 70, 20, 0, 0, 0, 1, 5, 1, 0};
    vecs[14] = '{1, 1, 6, 71, 21, 1, 4, 0, 1, 6, 2, 0};
    vecs[15] = '{1, 1, 7, 72, 22, 0, 0, 0, 1, 7, 2, 1};
    vecs[16] = '{0, 0, 0, 0, 0,   1, 5, 0, 1, 7, 2, 0};
    vecs[17] = '{0, 0, 0, 0, 0,   1, 6, 0, 1, 7, 1, 1};
    vecs[18] = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 7, 0, 1};
    vecs[19] = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 7, 0, 0};
    vecs[20] = '{0, 0, 0, 0, 0,   1, 20, 0, 1, 7, 0, 0};
    vecs[21] = '{0, 0, 0, 0, 0,   0, 0, 0, 1, 7, 0, 0};

    idle_inputs();
    SIG_RST = 1;
    tick();
    tick();
    check_reset_state("reset_init");
    SIG_RST = 0;

    // Reset with live entries.
    for (int i = 0; i < 3; i++) alloc(1, i + 1, 20 + i, 30 + i, 0);
    check("prefill_count", count, 3);
    SIG_RST = 1;
    wb_valid = 1; wb_idx = 0;
    tick();
    wb_valid = 0;
    check_reset_state("reset_filled");
    SIG_RST = 0;

    // Vector table: in-order retire, no-dst, alloc+commit, invalid writeback.
    for (int i = 0; i < 22; i++) begin
      alloc_valid = vecs[i].av; alloc_dst_valid = vecs[i].dv;
      alloc_dst_areg = vecs[i].areg; alloc_dst_preg = vecs[i].dp;
      alloc_prev_preg = vecs[i].pp;
      wb_valid = vecs[i].wv; wb_idx = vecs[i].wi; wb_exc = vecs[i].we;
      if (vecs[i].av) cq.push_back('{preg: vecs[i].pp, free: vecs[i].dv});
      tick();
      check($sformatf("vec%0d_ready", i), alloc_ready, vecs[i].exp_ready);
      check($sformatf("vec%0d_idx", i), alloc_idx, vecs[i].exp_idx);
      check($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
      check($sformatf("vec%0d_commit_valid", i), commit_valid, vecs[i].exp_cv);
    end
    idle_inputs();
    check("vec_commits_drained", cq.size(), 0);

    // Full and wrap.
    do_reset();
    for (int i = 0; i < 32; i++) alloc(1, i, 64 + i, i, i == 0);
    check("full_ready", alloc_ready, 0);
    check("full_count", count, 32);
    check("full_idx", alloc_idx, 0);
    alloc_valid = 1;
    tick();
    check("full_drop_count", count, 32);
    wb_valid = 1; wb_idx = 0;
    tick();
    wb_valid = 0;
    check("full_wb_count", count, 32);
    tick();                          // commit fires, same-cycle alloc dropped
    alloc_valid = 0;
    check("wrap_commit_seen", commit_valid, 1);
    check("wrap_count", count, 31);
    check("wrap_ready", alloc_ready, 1);
    check("wrap_idx", alloc_idx, 0);
    check("wrap_commits_drained", cq.size(), 0);

    // Exception at head index 0.
    do_reset();
    for (int i = 0; i < 4; i++) alloc(1, i + 1, 60 + i, 10 + i, 0);
    for (int i = 3; i >= 0; i--)
      rbq.push_back('{areg: 5'(i + 1), prev: 7'(10 + i), freep: 7'(60 + i)});
    wb_drive(0, 1);
    run_walk(4, 0, 0);
    check("exc1_idx", alloc_idx, 0);
    check("exc1_ready", alloc_ready, 1);

    // Exception at head index 1, a no-dst entry, writeback during the walk.
    alloc(1, 9, 90, 30, 1);
    for (int k = 1; k <= 4; k++) alloc(k != 3, 10 + k, 79 + k, 19 + k, 0);
    for (int k = 4; k >= 1; k--)
      if (k != 3) rbq.push_back('{areg: 5'(10 + k), prev: 7'(19 + k), freep: 7'(79 + k)});
    wb_drive(0, 0);
    wb_drive(1, 1);
    check("exc2_commit_drained", cq.size(), 0);
    run_walk(4, 1, 1);
    check("exc2_idx", alloc_idx, 1);

    // Reset in the middle of a walk.
    for (int k = 0; k < 4; k++) alloc(1, k + 1, 100 + k, 50 + k, 0);
    rbq.push_back('{areg: 5'd4, prev: 7'd53, freep: 7'd103});
    wb_drive(1, 1);
    tick();
    check("midwalk_ready", alloc_ready, 0);
    tick();
    check("midwalk_rb_drained", rbq.size(), 0);
    SIG_RST = 1;
    tick();
    SIG_RST = 0;
    check_reset_state("reset_midwalk");
    alloc(1, 2, 5, 6, 1);
    wb_drive(0, 0);
    tick();
    check("post_reset_commit", cq.size(), 0);
    check("post_reset_count", count, 0);

    check("final_rb_empty", rbq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
